// File: rtl/mau_pkg.sv
// Shared types, size/fault codes and the request checker for mem_access_unit.
// Honours MAU_SUBWORD_EN: when undefined, byte and half sizes are treated as misaligned.
package mau_pkg;

  localparam int MEM_WORDS_DEF  = 512;
  localparam int IMEM_WORDS_DEF = 256;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ      = 3'd1,
    ST_WRITE     = 3'd2,
    ST_RMW_READ  = 3'd3,
    ST_RMW_WRITE = 3'd4,
    ST_RESP      = 3'd5
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_RANGE    = 2'b10;
  localparam logic [1:0] FLT_WPROT    = 2'b11;

  // Priority: misaligned/reserved size, then range, then write-protect.
  function automatic logic [1:0] check_access(
    input logic [31:0] addr,
    input logic [1:0]  size,
    input logic        is_store,
    input logic        is_fetch,
    input logic [31:0] mem_bytes,
    input logic [31:0] imem_bytes
  );
    logic misalign;
    misalign = 1'b0;
    case (size)
      SZ_WORD: misalign = (addr[1:0] != 2'b00);
`ifdef MAU_SUBWORD_EN
      SZ_HALF: misalign = addr[0];
      SZ_BYTE: misalign = 1'b0;
`endif
      default: misalign = 1'b1;
    endcase
    if (misalign)
      check_access = FLT_MISALIGN;
    else if ((addr >= mem_bytes) || (is_fetch && (addr >= imem_bytes)))
      check_access = FLT_RANGE;
    else if (is_store && (addr < imem_bytes))
      check_access = FLT_WPROT;
    else
      check_access = FLT_NONE;
  endfunction

endpackage

// File: rtl/mau_lane.sv
// Little-endian byte-lane logic: merges store lanes into the old word and
// extracts/extends sub-word loads. Only instantiated when MAU_SUBWORD_EN is defined.
module mau_lane
  import mau_pkg::*;
(
  input  logic [1:0]  i_ofs,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_merged,
  output logic [31:0] o_load
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = i_rdata[{i_ofs, 3'b000} +: 8];
    w_half   = i_rdata[{i_ofs[1], 4'b0000} +: 16];
    o_merged = i_rdata;
    o_load   = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        o_merged[{i_ofs, 3'b000} +: 8] = i_wdata[7:0];
        o_load = i_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_merged[{i_ofs[1], 4'b0000} +: 16] = i_wdata[15:0];
        o_load = i_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: begin
        o_merged = i_wdata;
        o_load   = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory initiator arbitrating CPU fetch and load/store requests onto a single
// combinational-read memory port. Sub-word accesses exist only when MAU_SUBWORD_EN is defined.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int MEM_WORDS  = MEM_WORDS_DEF,
  parameter int IMEM_WORDS = IMEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [1:0]  data_size,
  input  logic        data_unsigned,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ready,
  output logic        data_valid,
  output logic [31:0] data_rdata,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        mem_write_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic [2:0]  dbg_state
);

  localparam logic [31:0] MEM_BYTES  = 32'(MEM_WORDS * 4);
  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

  // Handshake: a request transfers at the rising edge where req && ready;
  // ready is high only in IDLE outside reset, and the requester holds its
  // inputs until then. Data wins over fetch when both are asserted.
  state_t      r_state;
  logic        r_is_fetch;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_fetch_valid;
  logic        r_data_valid;
  logic [31:0] r_fetch_instr;
  logic [31:0] r_data_rdata;
  logic        r_fault;
  logic [1:0]  r_fault_code;

  logic        w_idle;
  logic        w_take_data;
  logic        w_take_fetch;
  logic        w_accept;
  logic        w_req_store;
  logic [31:0] w_req_addr;
  logic [1:0]  w_req_size;
  logic [1:0]  w_req_fault;
  logic [31:0] w_load_word;

  assign w_idle       = (r_state == ST_IDLE) && !rst;
  assign fetch_ready  = w_idle;
  assign data_ready   = w_idle;
  assign w_take_data  = w_idle && data_req;
  assign w_take_fetch = w_idle && fetch_req && !data_req;
  assign w_accept     = w_take_data || w_take_fetch;
  assign w_req_addr   = data_req ? data_addr : fetch_addr;
  assign w_req_size   = data_req ? data_size : SZ_WORD;
  assign w_req_store  = data_req && data_we;
  assign w_req_fault  = check_access(w_req_addr, w_req_size, w_req_store, !data_req,
                                     MEM_BYTES, IMEM_BYTES);

`ifdef MAU_SUBWORD_EN
  logic [1:0]  r_ofs;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_wdata;
  logic [31:0] w_merged_word;

  mau_lane u_lane (
    .i_ofs      (r_ofs),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .i_rdata    (mem_read_data),
    .o_merged   (w_merged_word),
    .o_load     (w_load_word)
  );
`else
  logic w_unused;
  assign w_unused    = data_unsigned;
  assign w_load_word = mem_read_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_is_fetch    <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_fetch_valid <= 1'b0;
      r_data_valid  <= 1'b0;
      r_fetch_instr <= '0;
      r_data_rdata  <= '0;
      r_fault       <= 1'b0;
      r_fault_code  <= FLT_NONE;
`ifdef MAU_SUBWORD_EN
      r_ofs         <= 2'b00;
      r_size        <= SZ_WORD;
      r_unsigned    <= 1'b0;
      r_wdata       <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_is_fetch <= w_take_fetch;
`ifdef MAU_SUBWORD_EN
            r_ofs      <= w_req_addr[1:0];
            r_size     <= w_req_size;
            r_unsigned <= data_unsigned;
            r_wdata    <= data_wdata;
`endif
            if (w_req_fault != FLT_NONE) begin
              r_state       <= ST_RESP;
              r_fault       <= 1'b1;
              r_fault_code  <= w_req_fault;
              r_fetch_valid <= w_take_fetch;
              r_data_valid  <= w_take_data;
              r_fetch_instr <= '0;
              r_data_rdata  <= '0;
            end else if (!w_req_store) begin
              r_state    <= ST_READ;
              r_mem_addr <= {w_req_addr[31:2], 2'b00};
            end else if (w_req_size == SZ_WORD) begin
              r_state     <= ST_WRITE;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= {w_req_addr[31:2], 2'b00};
              r_mem_wdata <= data_wdata;
            end else begin
`ifdef MAU_SUBWORD_EN
              r_state    <= ST_RMW_READ;
              r_mem_addr <= {w_req_addr[31:2], 2'b00};
`else
              r_state    <= ST_IDLE;
`endif
            end
          end
        end
        ST_READ: begin
          r_state    <= ST_RESP;
          r_mem_addr <= '0;
          if (r_is_fetch) begin
            r_fetch_valid <= 1'b1;
            r_fetch_instr <= mem_read_data;
          end else begin
            r_data_valid <= 1'b1;
            r_data_rdata <= w_load_word;
          end
        end
        ST_WRITE: begin
          r_state      <= ST_RESP;
          r_mem_we     <= 1'b0;
          r_mem_addr   <= '0;
          r_mem_wdata  <= '0;
          r_data_valid <= 1'b1;
          r_data_rdata <= '0;
        end
`ifdef MAU_SUBWORD_EN
        ST_RMW_READ: begin
          // Old word is folded into the write data here; the address is held.
          r_state     <= ST_RMW_WRITE;
          r_mem_we    <= 1'b1;
          r_mem_wdata <= w_merged_word;
        end
        ST_RMW_WRITE: begin
          r_state      <= ST_RESP;
          r_mem_we     <= 1'b0;
          r_mem_addr   <= '0;
          r_mem_wdata  <= '0;
          r_data_valid <= 1'b1;
          r_data_rdata <= '0;
        end
`endif
        ST_RESP: begin
          r_state       <= ST_IDLE;
          r_fetch_valid <= 1'b0;
          r_data_valid  <= 1'b0;
          r_fetch_instr <= '0;
          r_data_rdata  <= '0;
          r_fault       <= 1'b0;
          r_fault_code  <= FLT_NONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Gating with rst lets a reset abort a write in flight without a stray strobe.
  assign mem_write_enable = r_mem_we && !rst;
  assign mem_address      = r_mem_addr;
  assign mem_write_data   = r_mem_wdata;
  assign fetch_valid      = r_fetch_valid;
  assign fetch_instr      = r_fetch_instr;
  assign data_valid       = r_data_valid;
  assign data_rdata       = r_data_rdata;
  assign fault            = r_fault;
  assign fault_code       = r_fault_code;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded bench for mem_access_unit with a 512-word behavioural memory.
// Expectations for sub-word accesses follow whether MAU_SUBWORD_EN is defined.
`timescale 1ns/1ps
module tb_mem_access_unit;

`ifdef MAU_SUBWORD_EN
  localparam bit SUBW = 1'b1;
`else
  localparam bit SUBW = 1'b0;
`endif
  localparam int EW = 52;  // {due[15:0], is_fetch, fault, code[1:0], data[31:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready, fetch_valid;
  logic [31:0] fetch_instr;
  logic        data_req = 1'b0, data_we = 1'b0, data_unsigned = 1'b0;
  logic [1:0]  data_size = 2'b10;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic        data_ready, data_valid;
  logic [31:0] data_rdata;
  logic        fault;
  logic [1:0]  fault_code;
  logic        mem_write_enable;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [2:0]  dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .data_req(data_req), .data_we(data_we), .data_size(data_size),
    .data_unsigned(data_unsigned), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ready(data_ready), .data_valid(data_valid), .data_rdata(data_rdata),
    .fault(fault), .fault_code(fault_code),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .dbg_state(dbg_state)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [0:511];
  logic        poke_en = 1'b0;
  logic [8:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  int          cyc = 0;
  int          we_cycles = 0;

  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address[10:2]] <= mem_write_data;
    else if (poke_en) mem[poke_idx] <= poke_val;
  end
  assign mem_read_data = mem[mem_address[10:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write_enable) we_cycles <= we_cycles + 1;
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (fetch_valid || data_valid)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: fetch_valid=%b data_valid=%b expected none", fetch_valid, data_valid);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_kind", {30'b0, fetch_valid, data_valid}, {30'b0, mon_e[35], !mon_e[35]});
        check("resp_data", mon_e[35] ? fetch_instr : data_rdata, mon_e[31:0]);
        check("resp_fault", {29'b0, fault, fault_code}, {29'b0, mon_e[34:32]});
        check("resp_cycle", 32'(cyc), {16'b0, mon_e[51:36]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx[8:0]; poke_val = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
  endtask

  task automatic issue(input logic is_fetch, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input int lat, input logic flt, input logic [1:0] code,
                       input logic [31:0] expd);
    int n;
    @(negedge clk);
    if (is_fetch) begin
      fetch_req = 1'b1; fetch_addr = addr;
    end else begin
      data_req = 1'b1; data_we = we; data_size = size; data_unsigned = uns;
      data_addr = addr; data_wdata = wdata;
    end
    n = 0;
    while (!(is_fetch ? fetch_ready : data_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout: ready=0 after %0d cycles, required 1", n);
    end else begin
      exp_q.push_back({16'(cyc + lat), is_fetch, flt, code, expd});
    end
    @(negedge clk);
    fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
    drain();
  endtask

  // ---------------- stimulus ----------------
  int w0, n;
  logic [31:0] w400;

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", {31'b0, |{fetch_ready, fetch_valid, fetch_instr, data_ready,
          data_valid, data_rdata, fault, fault_code, mem_write_enable, mem_address,
          mem_write_data, dbg_state}}, 32'd0);
    poke(4, 32'h8C010100);
    poke(257, 32'hCAFEBABE);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {30'b0, fetch_ready, data_ready}, 32'd3);

    issue(1, 0, 2'b10, 0, 32'h10, 0, 2, 0, 2'b00, 32'h8C010100);

    w0 = we_cycles;
    issue(0, 1, 2'b10, 0, 32'h400, 32'hDEADBEEF, 2, 0, 2'b00, 32'h0);
    check("word_store_mem", mem[256], 32'hDEADBEEF);
    check("word_store_strobe", 32'(we_cycles - w0), 32'd1);
    issue(0, 0, 2'b10, 0, 32'h400, 0, 2, 0, 2'b00, 32'hDEADBEEF);
    issue(0, 1, 2'b10, 0, 32'h400, 32'h11223344, 2, 0, 2'b00, 32'h0);

    // Sub-word group: handled when lanes exist, otherwise misaligned faults.
    w0 = we_cycles;
    issue(0, 1, 2'b00, 0, 32'h401, 32'h000000AA, SUBW ? 3 : 1, !SUBW, SUBW ? 2'b00 : 2'b01, 32'h0);
    check("byte_store_mem", mem[256], SUBW ? 32'h1122AA44 : 32'h11223344);
    check("byte_store_strobe", 32'(we_cycles - w0), SUBW ? 32'd1 : 32'd0);
    issue(0, 0, 2'b00, 0, 32'h401, 0, SUBW ? 2 : 1, !SUBW, SUBW ? 2'b00 : 2'b01, SUBW ? 32'hFFFFFFAA : 32'h0);
    issue(0, 0, 2'b01, 1, 32'h402, 0, SUBW ? 2 : 1, !SUBW, SUBW ? 2'b00 : 2'b01, SUBW ? 32'h00001122 : 32'h0);
    issue(0, 0, 2'b01, 0, 32'h400, 0, SUBW ? 2 : 1, !SUBW, SUBW ? 2'b00 : 2'b01, SUBW ? 32'hFFFFAA44 : 32'h0);
    issue(0, 0, 2'b00, 1, 32'h403, 0, SUBW ? 2 : 1, !SUBW, SUBW ? 2'b00 : 2'b01, SUBW ? 32'h00000011 : 32'h0);
    issue(0, 1, 2'b01, 0, 32'h402, 32'h0000BEEF, SUBW ? 3 : 1, !SUBW, SUBW ? 2'b00 : 2'b01, 32'h0);
    w400 = SUBW ? 32'hBEEFAA44 : 32'h11223344;
    check("half_store_mem", mem[256], w400);

    // Faults: latency 1, no memory write.
    w0 = we_cycles;
    issue(0, 0, 2'b01, 0, 32'h403, 0, 1, 1, 2'b01, 32'h0);
    issue(0, 0, 2'b10, 0, 32'h800, 0, 1, 1, 2'b10, 32'h0);
    issue(0, 1, 2'b10, 0, 32'h10, 32'h55555555, 1, 1, 2'b11, 32'h0);
    issue(1, 0, 2'b10, 0, 32'h400, 0, 1, 1, 2'b10, 32'h0);
    issue(0, 0, 2'b11, 0, 32'h400, 0, 1, 1, 2'b01, 32'h0);
    issue(1, 0, 2'b10, 0, 32'h12, 0, 1, 1, 2'b01, 32'h0);
    check("fault_no_write", 32'(we_cycles - w0), 32'd0);
    check("fault_mem_intact", mem[4], 32'h8C010100);

    // Simultaneous requests: data first, fetch one IDLE cycle after data_valid.
    @(negedge clk);
    data_req = 1'b1; data_we = 1'b0; data_size = 2'b10; data_unsigned = 1'b0;
    data_addr = 32'h400; fetch_req = 1'b1; fetch_addr = 32'h10;
    n = 0;
    while (!data_ready && n < 50) begin @(negedge clk); n++; end
    check("arb_data_ready", {31'b0, data_ready}, 32'd1);
    exp_q.push_back({16'(cyc + 2), 1'b0, 1'b0, 2'b00, w400});
    exp_q.push_back({16'(cyc + 5), 1'b1, 1'b0, 2'b00, 32'h8C010100});
    @(negedge clk);
    data_req = 1'b0;
    n = 0;
    while (!fetch_ready && n < 50) begin @(negedge clk); n++; end
    check("arb_fetch_ready", {31'b0, fetch_ready}, 32'd1);
    @(negedge clk);
    fetch_req = 1'b0;
    drain();

    // Reset while in WRITE aborts the store.
    @(negedge clk);
    data_req = 1'b1; data_we = 1'b1; data_size = 2'b10; data_addr = 32'h404;
    data_wdata = 32'h12345678;
    w0 = we_cycles;
    check("rw_ready", {31'b0, data_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1; data_req = 1'b0; data_we = 1'b0;
    @(negedge clk);
    check("rw_in_write", {29'b0, dbg_state}, 32'd2);
    check("rw_we_low", {31'b0, mem_write_enable}, 32'd0);
    @(negedge clk);
    check("rw_outputs_zero", {31'b0, |{fetch_ready, fetch_valid, fetch_instr, data_ready,
          data_valid, data_rdata, fault, fault_code, mem_write_enable, mem_address,
          mem_write_data, dbg_state}}, 32'd0);
    check("rw_mem_intact", mem[257], 32'hCAFEBABE);
    check("rw_no_write", 32'(we_cycles - w0), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rw_ready_after", {31'b0, data_ready}, 32'd1);
    issue(0, 0, 2'b10, 0, 32'h404, 0, 2, 0, 2'b00, 32'hCAFEBABE);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
